// File: rtl/muldiv_sequencer_pkg.sv
// muldiv_sequencer_pkg: shared RV32M op/state encodings and special-case constants.
package muldiv_sequencer_pkg;
  typedef enum logic [2:0] {MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU} muldiv_op_e;
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} muldiv_state_e;
  localparam logic [31:0] DIV_ZERO_Q = 32'hFFFFFFFF;
  localparam logic [31:0] INT_MIN = 32'h80000000;
  function automatic logic a_signed(input muldiv_op_e op);
    return op inside {MUL, MULH, MULHSU, DIV, REM};
  endfunction
  function automatic logic b_signed(input muldiv_op_e op);
    return op inside {MUL, MULH, DIV, REM};
  endfunction
endpackage

// File: rtl/muldiv_iter_step.sv
// muldiv_iter_step: one radix-2 shift-add multiply or restoring-divide iteration on {hi, lo}.
module muldiv_iter_step #(
  parameter int XLEN = 32
) (
  input  logic            is_div,
  input  logic [XLEN-1:0] hi,
  input  logic [XLEN-1:0] lo,
  input  logic [XLEN-1:0] m,
  output logic [XLEN-1:0] hi_next,
  output logic [XLEN-1:0] lo_next
);
  logic [XLEN:0] sum, rem, diff;
  // Remainder stays below the divisor, so the 33-bit difference's MSB is a clean borrow.
  always_comb begin
    sum = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
    rem = {hi, lo[XLEN-1]};
    diff = rem - {1'b0, m};
    hi_next = is_div ? (diff[XLEN] ? rem[XLEN-1:0] : diff[XLEN-1:0]) : sum[XLEN:1];
    lo_next = is_div ? {lo[XLEN-2:0], ~diff[XLEN]} : {sum[0], lo[XLEN-1:1]};
  end
endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle RV32M controller; define MULDIV_FAST_MUL_EN for single-cycle multiplies.
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN)
) (
  input  logic            clk_i,
  input  logic            n_rst,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] operand_a_i,
  input  logic [XLEN-1:0] operand_b_i,
  input  logic            flush_i,
  output logic            ready_o,
  output logic            stall_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o
);
  muldiv_state_e state_q;
  muldiv_op_e op, op_q;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0] hi_q, lo_q, m_q, res_q;
  logic neg_q;
  logic sa, sb, div0, ovf, neg_n;
  logic [XLEN-1:0] abs_a, abs_b, spec_res, hi_n, lo_n, sel, fix_res;
  logic [2*XLEN-1:0] full, fixed;
  assign op = muldiv_op_e'(op_i);
  always_comb begin
    sa = a_signed(op) & operand_a_i[XLEN-1];
    sb = b_signed(op) & operand_b_i[XLEN-1];
    abs_a = sa ? -operand_a_i : operand_a_i;
    abs_b = sb ? -operand_b_i : operand_b_i;
    neg_n = (op == REM) ? sa : sa ^ sb;
    div0 = op_i[2] && operand_b_i == '0;
    ovf = (op == DIV || op == REM) && operand_a_i == XLEN'(INT_MIN) && operand_b_i == '1;
    spec_res = div0 ? (op_i[1] ? operand_a_i : XLEN'(DIV_ZERO_Q)) : (op_i[1] ? '0 : XLEN'(INT_MIN));
  end
  // Sign fix-up negates the full product so MULH* high words borrow correctly.
  always_comb begin
    sel = op_q[1] ? hi_q : lo_q;
    full = op_q[2] ? {{XLEN{1'b0}}, sel} : {hi_q, lo_q};
    fixed = neg_q ? -full : full;
    fix_res = (op_q == MUL || op_q[2]) ? fixed[XLEN-1:0] : fixed[2*XLEN-1:XLEN];
  end
  muldiv_iter_step #(.XLEN(XLEN)) u_step (
    .is_div  (op_q[2]),
    .hi      (hi_q),
    .lo      (lo_q),
    .m       (m_q),
    .hi_next (hi_n),
    .lo_next (lo_n)
  );
  always_ff @(posedge clk_i) begin
    if (n_rst) begin
      state_q <= IDLE;
      op_q <= MUL;
      cnt_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
      m_q <= '0;
      res_q <= '0;
      neg_q <= 1'b0;
    end else if (flush_i) begin
      state_q <= IDLE;
      cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (start_i) begin
          op_q <= op;
          neg_q <= neg_n;
          cnt_q <= '0;
          if (div0 || ovf) begin
            res_q <= spec_res;
            state_q <= DONE;
          end
`ifdef MULDIV_FAST_MUL_EN
          else if (!op_i[2]) begin
            {hi_q, lo_q} <= (2*XLEN)'(abs_a) * (2*XLEN)'(abs_b);
            state_q <= FIX;
          end
`endif
          else begin
            hi_q <= '0;
            lo_q <= op_i[2] ? abs_a : abs_b;
            m_q <= op_i[2] ? abs_b : abs_a;
            state_q <= CALC;
          end
        end
        CALC: begin
          hi_q <= hi_n;
          lo_q <= lo_n;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(XLEN - 1)) state_q <= FIX;
        end
        FIX: begin
          res_q <= fix_res;
          state_q <= DONE;
        end
        DONE: state_q <= IDLE;
      endcase
    end
  end
  assign ready_o = state_q == IDLE;
  assign stall_o = (state_q == IDLE && start_i && !flush_i) || state_q == CALC || state_q == FIX;
  assign valid_o = state_q == DONE;
  assign result_o = valid_o ? res_q : '0;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: table-driven vectors plus flush/reset corner sequences for muldiv_sequencer.
module tb_muldiv_sequencer;
  import muldiv_sequencer_pkg::*;
`ifdef MULDIV_FAST_MUL_EN
  localparam int LM = 2;
`else
  localparam int LM = 34;
`endif
  localparam int LD = 34;
  logic clk_i = 1'b0;
  logic n_rst = 1'b1;
  logic start_i = 1'b0;
  logic [2:0] op_i = 3'd0;
  logic [31:0] operand_a_i = '0;
  logic [31:0] operand_b_i = '0;
  logic flush_i = 1'b0;
  logic ready_o, stall_o, valid_o;
  logic [31:0] result_o;
  int total = 0;
  int bad = 0;
  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;
  vec_t vecs[18];
  muldiv_sequencer dut (
    .clk_i       (clk_i),
    .n_rst       (n_rst),
    .start_i     (start_i),
    .op_i        (op_i),
    .operand_a_i (operand_a_i),
    .operand_b_i (operand_b_i),
    .flush_i     (flush_i),
    .ready_o     (ready_o),
    .stall_o     (stall_o),
    .valid_o     (valid_o),
    .result_o    (result_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask
  task automatic run(input int idx, input vec_t v);
    int got_lat = -1;
    int errs = 0;
    logic [31:0] got_res = '0;
    @(posedge clk_i);
    #1;
    start_i = 1'b1;
    op_i = v.op;
    operand_a_i = v.a;
    operand_b_i = v.b;
    for (int k = 0; k <= 60; k++) begin
      @(negedge clk_i);
      if (stall_o !== (k < v.lat) || ready_o !== (k == 0) || (!valid_o && result_o !== '0)) errs++;
      if (valid_o) begin
        got_lat = k;
        got_res = result_o;
        break;
      end
      @(posedge clk_i);
      #1;
      start_i = 1'b0;
    end
    start_i = 1'b0;
    chk($sformatf("vec%0d_timing_errs", idx), errs, 0);
    chk($sformatf("vec%0d_latency", idx), got_lat, v.lat);
    chk($sformatf("vec%0d_result", idx), got_res, v.exp);
  endtask
  task automatic watch_no_valid(input string name);
    int seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk_i);
      if (valid_o) seen++;
    end
    chk(name, seen, 0);
  endtask
  initial begin
    vecs[0]  = '{MUL,    32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, LM};
    vecs[1]  = '{MULHU,  32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE, LM};
    vecs[2]  = '{MULHSU, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFF, LM};
    vecs[3]  = '{MULH,   32'hFFFFFFFE,   32'd3,        32'hFFFFFFFF, LM};
    vecs[4]  = '{MULH,   32'h80000000,   32'h80000000, 32'h40000000, LM};
    vecs[5]  = '{MUL,    32'h80000000,   32'hFFFFFFFF, 32'h80000000, LM};
    vecs[6]  = '{MUL,    32'd6,          32'd7,        32'd42,       LM};
    vecs[7]  = '{DIV,    32'hFFFFFFEC,   32'd6,        32'hFFFFFFFD, LD};
    vecs[8]  = '{REM,    32'hFFFFFFEC,   32'd6,        32'hFFFFFFFE, LD};
    vecs[9]  = '{DIVU,   32'd100,        32'd7,        32'd14,       LD};
    vecs[10] = '{REMU,   32'd100,        32'd7,        32'd2,        LD};
    vecs[11] = '{DIV,    32'd20,         32'hFFFFFFFA, 32'hFFFFFFFD, LD};
    vecs[12] = '{REM,    32'd20,         32'hFFFFFFFA, 32'd2,        LD};
    vecs[13] = '{DIVU,   32'h80000000,   32'hFFFFFFFF, 32'd0,        LD};
    vecs[14] = '{DIVU,   32'd5,          32'd0,        32'hFFFFFFFF, 1};
    vecs[15] = '{REMU,   32'd5,          32'd0,        32'd5,        1};
    vecs[16] = '{DIV,    32'h80000000,   32'hFFFFFFFF, 32'h80000000, 1};
    vecs[17] = '{REM,    32'hFFFFFFF9,   32'd0,        32'hFFFFFFF9, 1};
    repeat (2) @(posedge clk_i);
    #1;
    n_rst = 1'b0;
    @(negedge clk_i);
    chk("reset_ready", ready_o, 1);
    chk("reset_stall", stall_o, 0);
    chk("reset_valid", valid_o, 0);
    chk("reset_result", result_o, 0);
    for (int i = 0; i < 18; i++) run(i, vecs[i]);
    run(18, '{REM, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1});
    // Flush a divide in cycle 10.
    @(posedge clk_i);
    #1;
    start_i = 1'b1;
    op_i = DIV;
    operand_a_i = 32'd100;
    operand_b_i = 32'd7;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    repeat (9) @(posedge clk_i);
    #1;
    flush_i = 1'b1;
    @(posedge clk_i);
    #1;
    flush_i = 1'b0;
    chk("flush_ready", ready_o, 1);
    chk("flush_stall", stall_o, 0);
    watch_no_valid("flush_no_valid");
    // Start and flush together.
    @(posedge clk_i);
    #1;
    start_i = 1'b1;
    flush_i = 1'b1;
    op_i = DIVU;
    @(negedge clk_i);
    chk("startflush_stall", stall_o, 0);
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    flush_i = 1'b0;
    chk("startflush_ready", ready_o, 1);
    watch_no_valid("startflush_no_valid");
    // Reset in cycle 20 of a multiply.
    @(posedge clk_i);
    #1;
    start_i = 1'b1;
    op_i = MUL;
    operand_a_i = 32'd9;
    operand_b_i = 32'd9;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    repeat (19) @(posedge clk_i);
    #1;
    n_rst = 1'b1;
    @(posedge clk_i);
    #1;
    n_rst = 1'b0;
    chk("midrst_ready", ready_o, 1);
    chk("midrst_stall", stall_o, 0);
    chk("midrst_valid", valid_o, 0);
    chk("midrst_result", result_o, 0);
    watch_no_valid("midrst_no_valid");
    run(19, '{MULHU, 32'd6, 32'd7, 32'd0, LM});
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
